cfg_sequencer: RTL and testbench

Sequences each validated command frame from the SPI command depacker into the board's attenuator, phase-shifter and RF-control devices. One frame produces up to 8 device writes over a single shared serial-write port, in a fixed order with a req/ack handshake. The block sits between the depacker's ready/load handshake and the shared serial write master. It also owns the depacker's `load` strobe, so a new frame is never released while a write sequence is in flight.

---
 rtl/cfg_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cfg_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_sequencer.sv
`default_nettype none
// cfg_sequencer: replays each captured depacker frame as up to 8 ordered device writes over a req/ack port.
// Optional feature macro CFG_SKIP_UNCHANGED_EN: skip entries equal to their last acknowledged value.
module cfg_sequencer #(
    parameter int TIMEOUT = 4095,
    parameter int GAP     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_ready,
    output logic       cmd_load,
    input  logic [5:0] tx_att,
    input  logic [7:0] rx_ch1_att,
    input  logic [7:0] rx_ch2_att,
    input  logic [7:0] rx_ch3_att,
    input  logic [7:0] rx_ch1_pha,
    input  logic [7:0] rx_ch2_pha,
    input  logic [7:0] rx_ch3_pha,
    input  logic [2:0] mode,
    input  logic       rf_switch,
    output logic       wr_req,
    output logic [2:0] wr_dev,
    output logic [7:0] wr_data,
    input  logic       wr_ack,
    output logic       busy,
    output logic       done,
    output logic       wr_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEL  = 3'd2,
        S_REQ  = 3'd3,
        S_GAP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    state_t      after_entry;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  img_q [8];
    logic [2:0]  dev_q;
    logic [7:0]  data_q;
    logic        err_q;
    logic        skip;
    logic        capture;
    logic        issue;
    logic        expired;
    logic        tmo;

    assign expired     = (cnt_q == 12'(TIMEOUT - 1));
    assign capture     = (state_q == S_IDLE) && cmd_ready;
    assign issue       = (state_q == S_SEL) && !skip;
    // An ack in the expiry cycle wins over the timeout.
    assign tmo         = (state_q == S_REQ) && !wr_ack && expired;
    assign after_entry = (idx_q == 3'd7) ? S_FIN : S_SEL;

    assign cmd_load = (state_q == S_LOAD);
    assign wr_req   = (state_q == S_REQ);
    assign done     = (state_q == S_FIN);
    assign busy     = (state_q == S_LOAD) || (state_q == S_SEL) ||
                      (state_q == S_REQ)  || (state_q == S_GAP);
    assign wr_dev   = dev_q;
    assign wr_data  = data_q;
    assign wr_err   = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_ready) state_d = S_LOAD;
            end
            S_LOAD: begin
                idx_d   = 3'd0;
                state_d = S_SEL;
            end
            S_SEL: begin
                cnt_d = '0;
                if (skip) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = after_entry;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (wr_ack || expired) begin
                    cnt_d = '0;
                    if (GAP == 0) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = after_entry;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 12'(GAP - 1)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    state_d = after_entry;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dev_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) img_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                img_q[0] <= {2'b00, tx_att};
                img_q[1] <= rx_ch1_att;
                img_q[2] <= rx_ch2_att;
                img_q[3] <= rx_ch3_att;
                img_q[4] <= rx_ch1_pha;
                img_q[5] <= rx_ch2_pha;
                img_q[6] <= rx_ch3_pha;
                img_q[7] <= {4'b0000, rf_switch, mode};
                err_q    <= 1'b0;
            end
            if (issue) begin
                dev_q  <= idx_q;
                data_q <= img_q[idx_q];
            end
            if (tmo) err_q <= 1'b1;
        end
    end

`ifdef CFG_SKIP_UNCHANGED_EN
    logic [7:0] shadow_q [8];
    logic [7:0] valid_q;
    logic       ack_ok;

    assign ack_ok = (state_q == S_REQ) && wr_ack;
    assign skip   = valid_q[idx_q] && (shadow_q[idx_q] == img_q[idx_q]);

    // A timed-out entry loses its valid flag so the next frame retries it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
        end else if (ack_ok) begin
            shadow_q[idx_q] <= img_q[idx_q];
            valid_q[idx_q]  <= 1'b1;
        end else if (tmo) begin
            valid_q[idx_q] <= 1'b0;
        end
    end
`else
    assign skip = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_sequencer.sv
`default_nettype none
// tb_cfg_sequencer: randomized frames checked against a write-list reference model driven by a simple req/ack master.
module tb_cfg_sequencer;
    localparam int TIMEOUT = 4095;
    localparam int GAP     = 3;
`ifdef CFG_SKIP_UNCHANGED_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_ready;
    logic       cmd_load;
    logic [5:0] tx_att;
    logic [7:0] rx_ch1_att, rx_ch2_att, rx_ch3_att;
    logic [7:0] rx_ch1_pha, rx_ch2_pha, rx_ch3_pha;
    logic [2:0] mode;
    logic       rf_switch;
    logic       wr_req;
    logic [2:0] wr_dev;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       busy;
    logic       done;
    logic       wr_err;

    cfg_sequencer #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .tx_att(tx_att), .rx_ch1_att(rx_ch1_att), .rx_ch2_att(rx_ch2_att), .rx_ch3_att(rx_ch3_att),
        .rx_ch1_pha(rx_ch1_pha), .rx_ch2_pha(rx_ch2_pha), .rx_ch3_pha(rx_ch3_pha),
        .mode(mode), .rf_switch(rf_switch), .wr_req(wr_req), .wr_dev(wr_dev), .wr_data(wr_data),
        .wr_ack(wr_ack), .busy(busy), .done(done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] fv      [8];
    logic [7:0] nfv     [8];
    logic [7:0] tmp     [8];
    logic [7:0] mshadow [8];
    bit         mvalid  [8];
    int         dly     [8];
    int         n_checks = 0;
    int         n_errors = 0;
    int         last_nw  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq(tag, {cmd_load, wr_req, busy, done, wr_err, wr_dev, wr_data}, 32'd0);
    endtask

    task automatic rand_frame(input bit partial);
        for (int i = 0; i < 8; i++)
            if (!partial || $urandom_range(1) == 1) fv[i] = 8'($urandom);
        fv[0] = fv[0] & 8'h3F;
        fv[7] = fv[7] & 8'h0F;
    endtask

    task automatic drive_frame();
        tx_att     = fv[0][5:0];
        rx_ch1_att = fv[1];
        rx_ch2_att = fv[2];
        rx_ch3_att = fv[3];
        rx_ch1_pha = fv[4];
        rx_ch2_pha = fv[5];
        rx_ch3_pha = fv[6];
        mode       = fv[7][2:0];
        rf_switch  = fv[7][3];
    endtask

    task automatic scramble();
        tx_att     = 6'($urandom);
        rx_ch1_att = 8'($urandom);
        rx_ch2_att = 8'($urandom);
        rx_ch3_att = 8'($urandom);
        rx_ch1_pha = 8'($urandom);
        rx_ch2_pha = 8'($urandom);
        rx_ch3_pha = 8'($urandom);
        mode       = 3'($urandom);
        rf_switch  = 1'($urandom);
    endtask

    task automatic set_dly(input int lo, input int hi);
        for (int i = 0; i < 8; i++) dly[i] = $urandom_range(hi, lo);
    endtask

    // dly[i]==0 means the master never acks device i.
    task automatic run_frame(input bit preheld, input bit reassert, input int rst_dev);
        int exp_q[$];
        bit exp_err;
        int n, k, held, cur, prev_ref;
        bit prev_req, done_seen, load_again;
        exp_q   = {};
        exp_err = 1'b0;
        for (int i = 0; i < 8; i++)
            if (!(SKIP_EN && mvalid[i] && mshadow[i] == fv[i])) begin
                exp_q.push_back(i);
                if (dly[i] == 0) exp_err = 1'b1;
            end
        if (!preheld) begin
            @(negedge clk);
            drive_frame();
            cmd_ready = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_load && n < 50);
        check_eq("load_lat", n, preheld ? 2 : 1);
        check_eq("busy_at_load", busy, 1);
        cmd_ready = 1'b0;
        scramble();
        prev_ref   = cyc;
        k          = 0;
        held       = 0;
        cur        = 0;
        prev_req   = 1'b0;
        done_seen  = 1'b0;
        load_again = 1'b0;
        for (int c = 0; c < 20000 && !done_seen; c++) begin
            @(negedge clk);
            wr_ack = 1'b0;
            if (cmd_load) load_again = 1'b1;
            if (wr_req && !prev_req) begin
                cur = int'(wr_dev);
                if (k < exp_q.size()) begin
                    check_eq("wr_dev", wr_dev, exp_q[k]);
                    check_eq("wr_data", wr_data, fv[exp_q[k]]);
                    check_eq("req_start", cyc - prev_ref,
                             (k == 0) ? 2 + exp_q[0] : GAP + exp_q[k] - exp_q[k-1]);
                end else begin
                    check_eq("req_count", k + 1, exp_q.size());
                end
                held = 0;
                k++;
                if (cur == rst_dev) begin
                    rst = 1'b0;
                    @(negedge clk);
                    check_zero_outputs("rst_mid_write");
                    rst = 1'b1;
                    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
                    return;
                end
                if (reassert && k == 1) cmd_ready = 1'b1;
            end
            if (wr_req) begin
                held++;
                if (dly[cur] == held) wr_ack = 1'b1;
            end else begin
                if (prev_req) begin
                    check_eq("req_len", held, (dly[cur] == 0) ? TIMEOUT : dly[cur]);
                    prev_ref = cyc;
                end
                wr_ack = ($urandom_range(3) == 0);
            end
            if (done) begin
                done_seen = 1'b1;
                check_eq("n_writes", k, exp_q.size());
                check_eq("busy_at_done", busy, 0);
                check_eq("wr_err", wr_err, exp_err);
                check_eq("no_load_in_seq", load_again, 0);
                check_eq("done_lat", cyc - prev_ref, (k == 0) ? 9 : GAP + 7 - cur);
                foreach (exp_q[j]) begin
                    if (dly[exp_q[j]] == 0) mvalid[exp_q[j]] = 1'b0;
                    else begin
                        mshadow[exp_q[j]] = fv[exp_q[j]];
                        mvalid[exp_q[j]]  = 1'b1;
                    end
                end
                last_nw = k;
                if (reassert) begin
                    fv = nfv;
                    drive_frame();
                end
            end
            prev_req = wr_req;
        end
        wr_ack = 1'b0;
        check_eq("done_seen", done_seen, 1);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_ready = 1'b0;
        wr_ack    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fv[i]      = '0;
            mshadow[i] = '0;
            mvalid[i]  = 1'b0;
            dly[i]     = 2;
        end
        drive_frame();
        repeat (3) @(negedge clk);
        check_zero_outputs("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("after_reset");

        // Directed first frame: dev0 carries 8'h15, dev7 carries {rf_switch, mode} = 8'h0D.
        rand_frame(1'b0);
        fv[0] = 8'h15;
        fv[5] = 8'h11;
        fv[7] = 8'h0D;
        set_dly(2, 2);
        run_frame(1'b0, 1'b0, -1);
        check_eq("nwr_first", last_nw, 8);

        fv[5] = 8'h40;
        run_frame(1'b0, 1'b0, -1);
        check_eq("nwr_one_change", last_nw, SKIP_EN ? 1 : 8);

        // dev4 never acked, then the same frame again.
        rand_frame(1'b0);
        fv[4] = mshadow[4] ^ 8'h5A;
        set_dly(2, 2);
        dly[4] = 0;
        run_frame(1'b0, 1'b0, -1);
        set_dly(1, 1);
        run_frame(1'b0, 1'b0, -1);
        check_eq("nwr_retry", last_nw, SKIP_EN ? 1 : 8);

        // Reset during the dev3 request; the same values afterwards must all be written.
        rand_frame(1'b0);
        fv[3] = mshadow[3] ^ 8'h01;
        set_dly(1, 4);
        run_frame(1'b0, 1'b0, 3);
        tmp = fv;
        rand_frame(1'b1);
        nfv = fv;
        fv  = tmp;
        set_dly(1, 4);
        run_frame(1'b0, 1'b1, -1);
        check_eq("nwr_after_rst", last_nw, 8);
        set_dly(1, 3);
        run_frame(1'b1, 1'b0, -1);

        // Ack lands exactly in the expiry cycle.
        rand_frame(1'b0);
        fv[2] = mshadow[2] ^ 8'h80;
        set_dly(1, 1);
        dly[2] = TIMEOUT;
        run_frame(1'b0, 1'b0, -1);

        for (int f = 0; f < 6; f++) begin
            rand_frame(1'b1);
            set_dly(1, 5);
            run_frame(1'b0, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
